// File: rtl/id_branch_unit_pkg.sv
// Shared definitions for the ID-stage branch unit.
// Holds the branch opcode encodings, the instruction field bit positions
// and the bubble instruction value used on flush.
package id_branch_unit_pkg;

    localparam logic [5:0] OP_BEZ = 6'd40;   // branch if reg1 == 0
    localparam logic [5:0] OP_BNE = 6'd41;   // branch if reg1 != reg2
    localparam logic [5:0] OP_JMP = 6'd42;   // unconditional

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int SRC1_MSB   = 25;
    localparam int SRC1_LSB   = 21;
    localparam int SRC2_MSB   = 20;
    localparam int SRC2_LSB   = 16;
    localparam int IMM_MSB    = 15;
    localparam int IMM_LSB    = 0;

    localparam logic [31:0] NOP_INSN = 32'd0;

endpackage

// File: rtl/id_branch_unit_if.sv
// Fetch <-> decode link.
//   if_instruction / if_pc_value : fetched instruction and its PC+4 (fetch -> decode)
//   branch_taken / branch_address: redirect request and target (decode -> fetch)
//   if_freeze                    : hazard stall forwarded to the fetch PC hold
// master = fetch stage side, slave = decode stage side.
interface id_branch_unit_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] if_instruction;
    logic [WIDTH-1:0] if_pc_value;
    logic             branch_taken;
    logic [WIDTH-1:0] branch_address;
    logic             if_freeze;

    modport master (
        output if_instruction,
        output if_pc_value,
        input  branch_taken,
        input  branch_address,
        input  if_freeze
    );

    modport slave (
        input  if_instruction,
        input  if_pc_value,
        output branch_taken,
        output branch_address,
        output if_freeze
    );
endinterface

// File: rtl/id_branch_unit_branch_cond.sv
// Branch condition compare (purely combinational).
//   opcode   in : opcode field of the IF/ID instruction
//   reg1_val in : register data for src1
//   reg2_val in : register data for src2
//   taken    out: condition satisfied (not yet qualified by the valid bit)
module id_branch_unit_branch_cond
    import id_branch_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [5:0]       opcode,
    input  logic [WIDTH-1:0] reg1_val,
    input  logic [WIDTH-1:0] reg2_val,
    output logic             taken
);

    always_comb begin
        taken = 1'b0;
        case (opcode)
            OP_BEZ:  taken = (reg1_val == '0);
            OP_BNE:  taken = (reg1_val != reg2_val);
            OP_JMP:  taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/id_branch_unit.sv
// Instruction-decode front end: IF/ID pipeline register plus branch resolution.
//   clock, reset   : rising-edge clock, asynchronous active-high reset
//   fetch (slave)  : if_instruction/if_pc_value in, branch_taken/branch_address/if_freeze out
//   freeze         : hazard stall, IF/ID holds
//   reg1_val/reg2_val : register-file data for src1/src2
//   src1/src2      : register specifiers taken from the IF/ID instruction
//   id_instruction/id_pc_value/id_valid : IF/ID register contents
//   branch_count   : taken branches since reset (wraps)
// A taken branch flushes the wrong-path instruction in the next edge, giving a
// single bubble; the bubble itself can never branch.
module id_branch_unit
    import id_branch_unit_pkg::*;
#(
    parameter int               WIDTH = 32,
    parameter logic [WIDTH-1:0] NOP   = WIDTH'(NOP_INSN),
    parameter int               CNT_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    id_branch_unit_if.slave   fetch,
    input  logic              freeze,
    input  logic [WIDTH-1:0]  reg1_val,
    input  logic [WIDTH-1:0]  reg2_val,
    output logic [4:0]        src1,
    output logic [4:0]        src2,
    output logic [WIDTH-1:0]  id_instruction,
    output logic [WIDTH-1:0]  id_pc_value,
    output logic              id_valid,
    output logic [CNT_W-1:0]  branch_count
);

    logic [WIDTH-1:0] id_instruction_reg;
    logic [WIDTH-1:0] id_pc_value_reg;
    logic             id_valid_reg;
    logic [CNT_W-1:0] branch_count_reg;

    logic [5:0]       opcode;
    logic [15:0]      imm;
    logic [WIDTH-1:0] imm_sext;
    logic [WIDTH-1:0] branch_offset;
    logic             cond_taken;
    logic             branch_taken;

    assign opcode = id_instruction_reg[OPCODE_MSB:OPCODE_LSB];
    assign src1   = id_instruction_reg[SRC1_MSB:SRC1_LSB];
    assign src2   = id_instruction_reg[SRC2_MSB:SRC2_LSB];
    assign imm    = id_instruction_reg[IMM_MSB:IMM_LSB];

    // Sign extension: replicate the immediate sign bit into every upper bit.
    assign imm_sext[15:0] = imm;
    generate
        for (genvar gi = 16; gi < WIDTH; gi++) begin : g_sext
            assign imm_sext[gi] = imm[15];
        end
    endgenerate

    // Word offset; the add wraps modulo 2^WIDTH with no overflow signalling.
    assign branch_offset = {imm_sext[WIDTH-3:0], 2'b00};

    id_branch_unit_branch_cond #(
        .WIDTH (WIDTH)
    ) u_branch_cond (
        .opcode   (opcode),
        .reg1_val (reg1_val),
        .reg2_val (reg2_val),
        .taken    (cond_taken)
    );

    // A bubble must never redirect, regardless of what the stale fields decode to.
    assign branch_taken = id_valid_reg & cond_taken;

    assign fetch.branch_taken   = branch_taken;
    assign fetch.branch_address = id_pc_value_reg + branch_offset;
    assign fetch.if_freeze      = freeze;

    assign id_instruction = id_instruction_reg;
    assign id_pc_value    = id_pc_value_reg;
    assign id_valid       = id_valid_reg;
    assign branch_count   = branch_count_reg;

    // Flush has priority over freeze: fetch redirects on branch_taken no matter
    // what, so the wrong-path entry has to be dropped even while stalled.
    // The PC is kept on flush so the bubble still carries a sensible address.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            id_instruction_reg <= NOP;
            id_pc_value_reg    <= '0;
            id_valid_reg       <= 1'b0;
            branch_count_reg   <= '0;
        end else begin
            if (branch_taken) begin
                id_instruction_reg <= NOP;
                id_valid_reg       <= 1'b0;
                branch_count_reg   <= branch_count_reg + CNT_W'(1);
            end else if (!freeze) begin
                id_instruction_reg <= fetch.if_instruction;
                id_pc_value_reg    <= fetch.if_pc_value;
                id_valid_reg       <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_id_branch_unit.sv
// Self-checking bench for id_branch_unit: directed scenarios followed by a
// randomized run, with expected outputs queued at drive time and compared
// on the falling edge after the IF/ID update.
module tb_id_branch_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        freeze = 1'b0;
    logic [31:0] reg1_val = '0;
    logic [31:0] reg2_val = '0;
    logic [4:0]  src1, src2;
    logic [31:0] id_instruction, id_pc_value;
    logic        id_valid;
    logic [15:0] branch_count;

    id_branch_unit_if #(.WIDTH(32)) fetch_if ();

    id_branch_unit dut (
        .clock          (clock),
        .reset          (reset),
        .fetch          (fetch_if.slave),
        .freeze         (freeze),
        .reg1_val       (reg1_val),
        .reg2_val       (reg2_val),
        .src1           (src1),
        .src2           (src2),
        .id_instruction (id_instruction),
        .id_pc_value    (id_pc_value),
        .id_valid       (id_valid),
        .branch_count   (branch_count)
    );

    always #5 clock = ~clock;

    int check_cnt = 0;
    int pass_cnt  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s got=%08h expected=%08h", tag, got, exp);
    endtask

    // Reference model of the IF/ID register and counter.
    logic [31:0] m_insn  = '0;
    logic [31:0] m_pc    = '0;
    logic        m_valid = 1'b0;
    logic [15:0] m_cnt   = '0;

    typedef struct {
        string       tag;
        logic [31:0] insn;
        logic [31:0] pc;
        logic        valid;
        logic        taken;
        logic [31:0] addr;
        logic [15:0] cnt;
        logic [4:0]  s1;
        logic [4:0]  s2;
    } exp_t;

    exp_t sb_q[$];

    function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] a,
                                        input logic [4:0] b, input logic [15:0] imm);
        return {op, a, b, imm};
    endfunction

    function automatic logic m_taken(input logic [31:0] insn, input logic v,
                                     input logic [31:0] r1, input logic [31:0] r2);
        logic [5:0] op;
        op = insn[31:26];
        if (!v) return 1'b0;
        if (op == 6'd40) return (r1 == 32'd0);
        if (op == 6'd41) return (r1 != r2);
        if (op == 6'd42) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_addr(input logic [31:0] pc, input logic [31:0] insn);
        logic [31:0] off;
        off = {{14{insn[15]}}, insn[15:0], 2'b00};
        return pc + off;
    endfunction

    task automatic model_reset();
        m_insn  = '0;
        m_pc    = '0;
        m_valid = 1'b0;
        m_cnt   = '0;
    endtask

    task automatic compare_out();
        exp_t e;
        if (sb_q.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
            return;
        end
        e = sb_q.pop_front();
        check({e.tag, ".insn"},  id_instruction,          e.insn);
        check({e.tag, ".pc"},    id_pc_value,             e.pc);
        check({e.tag, ".valid"}, 32'(id_valid),           32'(e.valid));
        check({e.tag, ".taken"}, 32'(fetch_if.branch_taken), 32'(e.taken));
        check({e.tag, ".addr"},  fetch_if.branch_address, e.addr);
        check({e.tag, ".cnt"},   32'(branch_count),       32'(e.cnt));
        check({e.tag, ".src1"},  32'(src1),               32'(e.s1));
        check({e.tag, ".src2"},  32'(src2),               32'(e.s2));
        $display("txn %-8s insn=%08h pc=%08h valid=%0b taken=%0b addr=%08h cnt=%0d",
                 e.tag, id_instruction, id_pc_value, id_valid,
                 fetch_if.branch_taken, fetch_if.branch_address, branch_count);
    endtask

    // Drive one fetch cycle (called at a falling edge), predict the state after
    // the next rising edge, then compare at the following falling edge.
    task automatic drive(input string tag, input logic [31:0] insn, input logic [31:0] pc,
                         input logic frz, input logic [31:0] r1, input logic [31:0] r2);
        exp_t e;
        fetch_if.if_instruction = insn;
        fetch_if.if_pc_value    = pc;
        freeze                  = frz;
        reg1_val                = r1;
        reg2_val                = r2;
        if (m_taken(m_insn, m_valid, r1, r2)) begin
            m_cnt   = m_cnt + 16'd1;
            m_insn  = 32'd0;
            m_valid = 1'b0;
        end else if (!frz) begin
            m_insn  = insn;
            m_pc    = pc;
            m_valid = 1'b1;
        end
        e.tag   = tag;
        e.insn  = m_insn;
        e.pc    = m_pc;
        e.valid = m_valid;
        e.taken = m_taken(m_insn, m_valid, r1, r2);
        e.addr  = m_addr(m_pc, m_insn);
        e.cnt   = m_cnt;
        e.s1    = m_insn[25:21];
        e.s2    = m_insn[20:16];
        sb_q.push_back(e);
        @(posedge clock);
        @(negedge clock);
        compare_out();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ins_a, ins_b, ins_c, ins_d, bez, bne, jmp;
        fetch_if.if_instruction = '0;
        fetch_if.if_pc_value    = '0;
        ins_a = enc(6'd1, 5'd1, 5'd2, 16'h0011);
        ins_b = enc(6'd2, 5'd3, 5'd4, 16'h0022);
        ins_c = enc(6'd3, 5'd5, 5'd6, 16'h0033);
        ins_d = enc(6'd4, 5'd7, 5'd8, 16'h0044);
        bez   = enc(6'd40, 5'd1, 5'd2, 16'hFFFE);
        bne   = enc(6'd41, 5'd3, 5'd4, 16'h0010);

        // Reset state.
        @(negedge clock);
        @(negedge clock);
        check("rst.insn",  id_instruction, 32'd0);
        check("rst.pc",    id_pc_value, 32'd0);
        check("rst.valid", 32'(id_valid), 32'd0);
        check("rst.taken", 32'(fetch_if.branch_taken), 32'd0);
        check("rst.addr",  fetch_if.branch_address, 32'd0);
        check("rst.cnt",   32'(branch_count), 32'd0);
        reset = 1'b0;
        model_reset();

        // Sequential fetches.
        drive("seq4",  ins_a, 32'd4, 1'b0, 32'd1, 32'd2);
        check("seq4.valid_rise", 32'(id_valid), 32'd1);
        drive("seq8",  ins_b, 32'd8, 1'b0, 32'd1, 32'd2);
        drive("seq12", ins_c, 32'd12, 1'b0, 32'd1, 32'd2);
        check("seq12.pc", id_pc_value, 32'd12);

        // JMP +3 words from PC 0x10.
        jmp = enc(6'd42, 5'd0, 5'd0, 16'h0003);
        drive("jmp",    jmp, 32'h10, 1'b0, 32'd1, 32'd2);
        check("jmp.addr_const", fetch_if.branch_address, 32'h1C);
        drive("jmp_fl", ins_d, 32'h14, 1'b0, 32'd1, 32'd2);
        check("jmp_fl.valid_const", 32'(id_valid), 32'd0);
        check("jmp_fl.cnt_const", 32'(branch_count), 32'd1);
        drive("tgt",    ins_a, 32'h20, 1'b0, 32'd1, 32'd2);

        // BEZ taken then not taken.
        drive("bez_t",  bez, 32'h20, 1'b0, 32'd0, 32'd3);
        check("bez_t.addr_const", fetch_if.branch_address, 32'h18);
        drive("bez_fl", ins_b, 32'h24, 1'b0, 32'd0, 32'd3);
        drive("bez_n",  bez, 32'h20, 1'b0, 32'd5, 32'd3);
        check("bez_n.taken_const", 32'(fetch_if.branch_taken), 32'd0);
        drive("bez_nx", ins_c, 32'h24, 1'b0, 32'd5, 32'd3);
        check("bez_nx.pc_const", id_pc_value, 32'h24);

        // BNE held under freeze, then released by a register change.
        drive("bne",    bne, 32'h30, 1'b0, 32'd7, 32'd7);
        drive("bne_f1", ins_d, 32'h34, 1'b1, 32'd7, 32'd7);
        drive("bne_f2", ins_d, 32'h34, 1'b1, 32'd7, 32'd7);
        check("bne_f2.insn_const", id_instruction, bne);
        reg2_val = 32'd9;
        #1;
        check("bne.same_cycle_taken", 32'(fetch_if.branch_taken), 32'd1);
        drive("bne_fl", ins_d, 32'h34, 1'b1, 32'd7, 32'd9);
        check("bne_fl.valid_const", 32'(id_valid), 32'd0);
        drive("after",  ins_a, 32'h38, 1'b0, 32'd7, 32'd9);

        // Address wrap-around.
        jmp = enc(6'd42, 5'd0, 5'd0, 16'h0001);
        drive("wrap",   jmp, 32'hFFFFFFFC, 1'b0, 32'd1, 32'd2);
        check("wrap.addr_const", fetch_if.branch_address, 32'h0);

        // Asynchronous reset with a taken JMP in IF/ID.
        reset = 1'b1;
        #1;
        check("arst.taken", 32'(fetch_if.branch_taken), 32'd0);
        check("arst.cnt",   32'(branch_count), 32'd0);
        check("arst.valid", 32'(id_valid), 32'd0);
        model_reset();
        @(negedge clock);
        reset = 1'b0;

        // Randomized traffic.
        for (int i = 0; i < 30; i++) begin
            logic [5:0]  op;
            logic [31:0] ins;
            int          sel;
            sel = $urandom_range(0, 4);
            op  = (sel == 0) ? 6'd40 : (sel == 1) ? 6'd41 : (sel == 2) ? 6'd42 : 6'($urandom_range(0, 39));
            ins = enc(op, 5'($urandom), 5'($urandom), 16'($urandom));
            drive("rnd", ins, {$urandom_range(0, 1023), 2'b00}, ($urandom_range(0, 3) == 0),
                  32'($urandom_range(0, 2)), 32'($urandom_range(0, 2)));
        end

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/id_branch_unit.md
# id_branch_unit

Instruction-decode front end that receives the fetch stage's `instruction` and `pc_value` (PC+4) outputs. It holds them in an IF/ID pipeline register with valid, freeze and flush control, and resolves conditional and unconditional branches. It drives `branch_taken` and `branch_address` back to the fetch stage, closing the fetch/redirect loop with a one-cycle taken-branch penalty.

## Interface
- `WIDTH`, 32: instruction, PC and register data width.
- `NOP`, 32'd0: instruction value loaded into the register on a bubble or flush.
- `CNT_W`, 16: width of the taken-branch counter.
- `clock`  in  1: rising-edge clock, the only clock.
- `reset`  in  1: asynchronous, active-high reset.
- `if_instruction`  in  WIDTH: instruction from the fetch stage.
- `if_pc_value`  in  WIDTH: PC+4 of that instruction, from the fetch stage.
- `freeze`  in  1: hazard stall; the IF/ID register holds its contents.
- `reg1_val`  in  WIDTH: register-file read data for `src1`.
- `reg2_val`  in  WIDTH: register-file read data for `src2`.
- `src1`  out  5: `id_instruction[25:21]`.
- `src2`  out  5: `id_instruction[20:16]`.
- `id_instruction`  out  WIDTH: registered instruction.
- `id_pc_value`  out  WIDTH: registered PC+4.
- `id_valid`  out  1: the IF/ID entry holds a real instruction.
- `branch_taken`  out  1: redirect request to the fetch stage.
- `branch_address`  out  WIDTH: redirect target.
- `if_freeze`  out  1: equals `freeze`; routed to the fetch-stage PC hold.
- `branch_count`  out  CNT_W: number of taken branches since reset.

## Operation
- Opcode is `id_instruction[31:26]`. Immediate is `id_instruction[15:0]`, sign-extended to WIDTH.
- Branch conditions:
  - BEZ (6'd40): taken when `reg1_val == 0`.
  - BNE (6'd41): taken when `reg1_val != reg2_val`.
  - JMP (6'd42): always taken.
  - All other opcodes: not taken.
- `branch_address = id_pc_value + (sext(imm) << 2)`, modulo 2^WIDTH. Wrap-around is silent.
- `branch_taken` is combinational from the register contents and `reg*_val`, and is gated by `id_valid`. A bubble never branches.
- IF/ID register update at each `clock` edge, highest priority first:
  1. `branch_taken`: load `NOP`, clear `id_valid`, keep `id_pc_value`. This flushes the wrong-path instruction.
  2. `freeze`: hold all contents.
  3. Otherwise: load `if_instruction` and `if_pc_value`, set `id_valid`.
- Flush beats freeze. Rationale: the fetch stage redirects unconditionally on `branch_taken`, so the wrong-path instruction must be discarded.
- `branch_count` increments on every edge where `branch_taken` is high. It wraps from all-ones to 0.

## Timing
- Reset values:
  - `id_instruction = NOP`, `id_pc_value = 0`, `id_valid = 0`, `branch_count = 0`.
  - Therefore `branch_taken = 0` and `branch_address = 0 + (sext(0) << 2) = 0`.
- Reset applies immediately and asynchronously, including mid-branch. A pending redirect is dropped in the same cycle.
- Latency: fetch output appears on `id_*` one cycle later.
- Taken branch in IF/ID at cycle N:
  - Fetch loads `branch_address` at edge N+1.
  - The IF/ID entry is a bubble in cycle N+1.
  - The target instruction is in IF/ID in cycle N+2.
  - Penalty: one bubble.
- Back-to-back branches: the bubble after a taken branch cannot branch, so no double redirect is possible.
- Freeze on a branch entry with a false condition: the entry holds and re-evaluates every cycle. It redirects when the condition becomes true.

## Structure
- Shared package holds:
  - Opcode constants `OP_BEZ`, `OP_BNE`, `OP_JMP`.
  - Field bit positions for opcode, src1, src2 and imm.
  - The `NOP` value.
- One natural sub-module is `branch_cond`: a combinational compare that takes opcode, `reg1_val` and `reg2_val` and returns the taken decision.
- The pipeline register, counter, address adder (existing `Adder`) and gating stay in the top module.

## Test plan
- Reset then 3 sequential fetches (pc_value 4, 8, 12):
  - `id_pc_value` follows 4, 8, 12, each one cycle later.
  - `id_valid` rises 1 cycle after reset release.
  - `branch_taken` stays 0.
- JMP, imm = 16'h0003, pc_value = 32'h10:
  - `branch_taken = 1`, `branch_address = 32'h1C`.
  - Next cycle: `id_instruction = NOP`, `id_valid = 0`.
  - `branch_count = 1`.
- BEZ, imm = 16'hFFFE, pc_value = 32'h20:
  - With `reg1_val = 0`: target is 32'h18.
  - With `reg1_val = 5`: not taken, no flush.
- BNE with `reg1_val == reg2_val` under `freeze = 1` for 2 cycles:
  - Register holds and the branch is not taken.
  - Change `reg2_val` while frozen: taken in the same cycle, and the flush overrides freeze.
- JMP at pc_value = 32'hFFFFFFFC, imm = 1: `branch_address = 32'h0`, wrapping silently.
- Assert reset while a JMP is in IF/ID: `branch_taken` drops immediately and `branch_count` returns to 0.
